// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one one-hot ALU between two requesters.
// Optional operand screening is enabled by defining ONEHOT_CHECK_EN.
module alu_req_scheduler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_inp1,
  input  logic [15:0]      req0_inp2,
  input  logic [2:0]       req0_opc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_inp1,
  input  logic [15:0]      req1_inp2,
  input  logic [2:0]       req1_opc,
  output logic [15:0]      alu_inp1,
  output logic [15:0]      alu_inp2,
  output logic [2:0]       alu_opc,
  input  logic [15:0]      alu_out,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_out,
  output logic             rsp_overflow,
  output logic             rsp_error,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  logic             last_grant_reg;
  logic [15:0]      alu_inp1_reg, alu_inp2_reg;
  logic [2:0]       alu_opc_reg;
  logic             rsp_valid_reg, rsp_id_reg, rsp_overflow_reg;
  logic [15:0]      rsp_out_reg;
  logic [CNT_W-1:0] done_count_reg;

  logic             grant, accept;
  logic [15:0]      sel_inp1, sel_inp2;
  logic [2:0]       sel_opc;

  // On a tie the requester not served last time wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_reg;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = ~rst && (state_reg == IDLE) && ~grant;
  assign req1_ready = ~rst && (state_reg == IDLE) &&  grant;
  assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
  assign sel_inp1   = grant ? req1_inp1 : req0_inp1;
  assign sel_inp2   = grant ? req1_inp2 : req0_inp2;
  assign sel_opc    = grant ? req1_opc  : req0_opc;

`ifdef ONEHOT_CHECK_EN
  logic rsp_error_reg;
  logic operand_bad;

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'h0) && ((v & (v - 16'h1)) == 16'h0);
  endfunction

  assign operand_bad = ~is_onehot(sel_inp1) || ~is_onehot(sel_inp2);
  assign rsp_error   = rsp_error_reg;
`else
  assign rsp_error   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      last_grant_reg   <= 1'b1;
      alu_inp1_reg     <= '0;
      alu_inp2_reg     <= '0;
      alu_opc_reg      <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_id_reg       <= 1'b0;
      rsp_out_reg      <= '0;
      rsp_overflow_reg <= 1'b0;
      done_count_reg   <= '0;
`ifdef ONEHOT_CHECK_EN
      rsp_error_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rsp_id_reg     <= grant;
            last_grant_reg <= grant;
`ifdef ONEHOT_CHECK_EN
            // Malformed operands bypass the ALU and answer with an error.
            if (operand_bad) begin
              rsp_out_reg      <= '0;
              rsp_overflow_reg <= 1'b0;
              rsp_error_reg    <= 1'b1;
              rsp_valid_reg    <= 1'b1;
              state_reg        <= RESP;
            end else begin
              alu_inp1_reg <= sel_inp1;
              alu_inp2_reg <= sel_inp2;
              alu_opc_reg  <= sel_opc;
              state_reg    <= EXEC;
            end
`else
            alu_inp1_reg <= sel_inp1;
            alu_inp2_reg <= sel_inp2;
            alu_opc_reg  <= sel_opc;
            state_reg    <= EXEC;
`endif
          end
        end
        EXEC: begin
          rsp_out_reg      <= alu_out;
          rsp_overflow_reg <= alu_overflow;
`ifdef ONEHOT_CHECK_EN
          rsp_error_reg    <= 1'b0;
`endif
          rsp_valid_reg    <= 1'b1;
          state_reg        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg  <= 1'b0;
            done_count_reg <= done_count_reg + CNT_W'(1);
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign alu_inp1     = alu_inp1_reg;
  assign alu_inp2     = alu_inp2_reg;
  assign alu_opc      = alu_opc_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_id       = rsp_id_reg;
  assign rsp_out      = rsp_out_reg;
  assign rsp_overflow = rsp_overflow_reg;
  assign done_count   = done_count_reg;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench for alu_req_scheduler: stimulus pushes hand-computed
// responses, a negedge monitor pops and compares on each response handshake.
`timescale 1ns/1ps
module tb_alu_req_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_inp1 = '0, req0_inp2 = '0, req1_inp1 = '0, req1_inp2 = '0;
  logic [2:0]  req0_opc = '0, req1_opc = '0;
  logic [15:0] alu_inp1, alu_inp2, alu_out;
  logic [2:0]  alu_opc;
  logic        alu_overflow;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_overflow, rsp_error;
  logic [15:0] rsp_out;
  logic [7:0]  done_count;

  typedef struct {
    logic        id;
    logic [15:0] out;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  alu_req_scheduler #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_inp1(req0_inp1),
    .req0_inp2(req0_inp2), .req0_opc(req0_opc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_inp1(req1_inp1),
    .req1_inp2(req1_inp2), .req1_opc(req1_opc),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_opc(alu_opc),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_overflow(rsp_overflow), .rsp_error(rsp_error),
    .done_count(done_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int low_idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Bench ALU: opc 0 multiplies bit indices, otherwise adds them; result wraps mod 16.
  always_comb begin
    int p;
    p = (alu_opc == 3'd0) ? low_idx(alu_inp1) * low_idx(alu_inp2)
                          : low_idx(alu_inp1) + low_idx(alu_inp2);
    alu_out      = 16'h1 << p[3:0];
    alu_overflow = (p > 15);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 32'(rsp_out), 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_out", 32'(rsp_out), 32'(e.out));
        check("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
        check("rsp_error", 32'(rsp_error), 32'(e.err));
        $display("rsp id=%0d out=%04h ovf=%0d err=%0d count=%0d", rsp_id, rsp_out,
                 rsp_overflow, rsp_error, done_count);
      end
    end
  end

  // Presents one request; returns just after the accepting edge.
  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic [15:0] eo, input logic eov,
                       input logic eer, input bit push, output int waited);
    bit got = 0;
    exp_t e;
    waited = 0;
    if (id == 0) begin req0_inp1 = a; req0_inp2 = b; req0_opc = op; req0_valid = 1'b1; end
    else         begin req1_inp1 = a; req1_inp2 = b; req1_opc = op; req1_valid = 1'b1; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) got = 1;
      else waited++;
    end
    if (!got) check("accept_timeout", 32'(waited), 32'd0);
    else if (push) begin
      e.id = id[0]; e.out = eo; e.ovf = eov; e.err = eer;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    int acc;
    int acc_cyc[4];
    exp_t e;

    // Reset: readies held low even with a valid request.
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_done_count", 32'(done_count), 32'd0);
    check("rst_alu_inp1", 32'(alu_inp1), 32'd0);
    check("rst_rsp_out", 32'(rsp_out), 32'd0);
    @(posedge clk); #1;

    // Basic op: 2*4 -> bit 8.
    issue(0, 16'h0004, 16'h0010, 3'd0, 16'h0100, 1'b0, 1'b0, 1, w);
    check("basic_ready_same_cycle", 32'(w), 32'd0);
    @(negedge clk);
    check("basic_alu_inp1", 32'(alu_inp1), 32'h0004);
    check("basic_no_early_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("basic_rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("basic_done_count", 32'(done_count), 32'd1);
    drain();

    // Stall: req0 op 1+3 -> bit 4 held while req1 waits.
    rsp_ready = 1'b0;
    issue(0, 16'h0002, 16'h0008, 3'd1, 16'h0010, 1'b0, 1'b0, 1, w);
    req1_inp1 = 16'h0020; req1_inp2 = 16'h0004; req1_opc = 3'd0; req1_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_out", 32'(rsp_out), 32'h0010);
      check("stall_req1_ready", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_req1_accept_idle", 32'(req1_ready), 32'd1);
    e.id = 1'b1; e.out = 16'h0400; e.ovf = 1'b0; e.err = 1'b0;   // 5*2 -> bit 10
    exp_q.push_back(e);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();
    check("stall_done_count", 32'(done_count), 32'd3);

    // Fairness: both valid, expect 0,1,0,1 every 3 cycles.
    req0_inp1 = 16'h0008; req0_inp2 = 16'h0008; req0_opc = 3'd1;   // 3+3 -> bit 6
    req1_inp1 = 16'h0080; req1_inp2 = 16'h0002; req1_opc = 3'd0;   // 7*1 -> bit 7
    for (int k = 0; k < 4; k++) begin
      e.id = k[0]; e.out = k[0] ? 16'h0080 : 16'h0040; e.ovf = 1'b0; e.err = 1'b0;
      exp_q.push_back(e);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 60 && acc < 4; i++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
      if (acc == 4) begin @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    check("fair_accepts", 32'(acc), 32'd4);
    for (int k = 1; k < 4; k++)
      check("fair_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("fair_done_count_12cyc", 32'(done_count), 32'd7);
    drain();

    // Overflow: 4*4 = 16 wraps to bit 0.
    issue(0, 16'h0010, 16'h0010, 3'd0, 16'h0001, 1'b1, 1'b0, 1, w);
    drain();

    // Non-one-hot operand.
`ifdef ONEHOT_CHECK_EN
    issue(1, 16'h0006, 16'h0002, 3'd1, 16'h0000, 1'b0, 1'b1, 1, w);
    @(negedge clk);
    check("onehot_rsp_valid_early", 32'(rsp_valid), 32'd1);
    check("onehot_alu_inp1_kept", 32'(alu_inp1), 32'h0010);
`else
    issue(1, 16'h0006, 16'h0002, 3'd1, 16'h0004, 1'b0, 1'b0, 1, w);   // 1+1 -> bit 2
    @(negedge clk);
    check("onehot_rsp_valid_exec", 32'(rsp_valid), 32'd0);
    check("onehot_alu_inp1", 32'(alu_inp1), 32'h0006);
`endif
    drain();
    check("pre_reset_done_count", 32'(done_count), 32'd9);

    // Reset during EXEC drops the operation.
    issue(0, 16'h0004, 16'h0010, 3'd0, 16'h0100, 1'b0, 1'b0, 0, w);
    #2 rst = 1'b1;
    #1;
    check("midrst_done_count", 32'(done_count), 32'd0);
    check("midrst_alu_inp1", 32'(alu_inp1), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("midrst_done_count_after", 32'(done_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
# alu_req_scheduler

Round-robin scheduler sharing the one-hot ALU datapath (16-bit one-hot operands, 3-bit opcode, 16-bit one-hot result plus overflow) between two requesters. Each requester presents an operation over a valid/ready handshake. The block grants one requester, drives registered operands to the ALU for one execute cycle, and captures the result. It returns the result with the requester ID over a valid/ready response channel and counts completed operations.

## Interface
- `CNT_W`, default 8: width of the completed-operation counter.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1, `req0_ready` out 1: requester 0 handshake.
- `req0_inp1`, `req0_inp2` in 16: requester 0 one-hot operands. `req0_opc` in 3: opcode.
- `req1_valid` in 1, `req1_ready` out 1, `req1_inp1` in 16, `req1_inp2` in 16, `req1_opc` in 3: requester 1, same meanings.
- `alu_inp1`, `alu_inp2` out 16, `alu_opc` out 3: registered drive to the shared ALU.
- `alu_out` in 16, `alu_overflow` in 1: combinational ALU result.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: requester served (0/1).
- `rsp_out` out 16, `rsp_overflow` out 1: captured result.
- `rsp_error` out 1: operand check failure (see Configuration).
- `done_count` out CNT_W: completed responses, wraps modulo 2^CNT_W.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - EXEC: ALU settling.
  - RESP: response held.
- IDLE:
  - `grant` is combinational. Only one valid: that one wins. Both valid: `~last_grant` wins.
  - `reqN_ready` = (state==IDLE) && (grant==N). At most one ready is high.
  - Transfer occurs on `valid && ready`. Latch `inp1`, `inp2`, `opc` into the operand registers that drive `alu_*`. Latch the ID and set `last_grant` to the ID. Go to EXEC.
- EXEC, one cycle: at its closing edge, capture `alu_out` into `rsp_out` and `alu_overflow` into `rsp_overflow`, set `rsp_error` = 0, go to RESP.
- RESP:
  - `rsp_valid` = 1, with `rsp_*` stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: `done_count` += 1 (wraps), go to IDLE.
  - Both `reqN_ready` are 0 in EXEC and RESP.
- `alu_*` hold the last operands outside EXEC; they change only on acceptance.
- Requester operands are sampled only at the transfer edge. Later changes are ignored.

## Timing
- Reset values:
  - state IDLE, `last_grant` = 1 (requester 0 wins the first tie).
  - `alu_inp1`, `alu_inp2`, `alu_opc`, `rsp_out`, `rsp_overflow`, `rsp_error`, `rsp_id` all 0.
  - `rsp_valid` = 0, `done_count` = 0, both readies 0 while `rst` is high.
- Latency:
  - Accept at edge N, EXEC during N..N+1, `rsp_valid` high after edge N+1.
  - Best-case throughput is one operation per 3 cycles when `rsp_ready` is held high.
- A held `rsp_ready` = 0 stalls indefinitely. No new acceptance occurs during the stall.
- Response and acceptance are not overlapped: IDLE is always visited for one cycle after a response handshake.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- Reset mid-operation clears all state immediately. An in-flight operation is dropped with no response and no count increment; the requester must re-present it.
- `done_count` wraps from 2^CNT_W−1 to 0 without a flag.

## Configuration
- `ONEHOT_CHECK_EN` defined:
  - At acceptance, if `inp1` or `inp2` is not exactly one-hot (zero or multiple bits set), skip EXEC and go directly to RESP.
  - The response carries `rsp_out` = 0, `rsp_overflow` = 0, `rsp_error` = 1.
  - `alu_*` are not updated. `done_count` increments on the handshake as normal.
- `ONEHOT_CHECK_EN` undefined: no check, every request executes, `rsp_error` tied to 0.

## Test plan
- Reset, then `req0` valid with `inp1` = 16'h0004, `inp2` = 16'h0010, `opc` = 3'b000, bench ALU returns 16'h0100, overflow 0 → `req0_ready` high in the same cycle; `alu_inp1` = 16'h0004 one cycle later; `rsp_valid` two edges after acceptance with `rsp_id` = 0, `rsp_out` = 16'h0100; `done_count` = 1 after the handshake.
- Both requesters continuously valid, `rsp_ready` = 1 → grant order 0,1,0,1; responses every 3 cycles; `done_count` = 4 after 12 cycles of operation.
- `rsp_ready` = 0 for 10 cycles with `req1` valid → `rsp_*` stable, `req1_ready` = 0 throughout; `req1` accepted in the IDLE cycle after `rsp_ready` rises.
- Bench ALU overflow = 1 with `alu_out` = 16'h0001 → `rsp_overflow` = 1, `rsp_out` = 16'h0001.
- Assert `rst` during EXEC → `rsp_valid` never rises for that operation, `done_count` = 0, `alu_inp1` = 0.
- With `ONEHOT_CHECK_EN`: `inp1` = 16'h0006 → `rsp_valid` one edge after acceptance, `rsp_error` = 1, `rsp_out` = 0, `alu_*` unchanged. Without the macro, the same stimulus executes normally with `rsp_error` = 0.
